laser_pulse_ctrl: RTL and testbench
===================================

# laser_pulse_ctrl

Sequences laser trigger pulses once the laser reports ready and enforces safety limits on them. It fixes each pulse width, enforces a minimum gap between pulses, and caps the number of pulses per rolling time window. Any external fault or loss of the ready signal latches a shutdown that needs an explicit clear. It sits between the laser power-up timer (`laser_ready`) and the laser driver trigger/enable pins.

## Interface
- `PULSE_W`, default 100: trigger high time in clk cycles (≥1).
- `MIN_GAP`, default 1000: forced low time after each pulse, in cycles (≥1).
- `WINDOW`, default 1000000: length of the pulse-budget window in cycles (≥2).
- `MAX_PULSES`, default 50: accepted pulses allowed per window (≥1).
- `clk` in 1: single system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `laser_ready` in 1: laser power-up complete. Already synchronous to `clk`.
- `trig_req` in 1: pulse request, sampled every cycle. Each high cycle counts as one request.
- `fault_in` in 1: external safety fault, active high, synchronous.
- `fault_clr` in 1: request to leave FAULT.
- `laser_en` out 1: laser enable to the driver.
- `trig_out` out 1: laser trigger.
- `state` out 3: current FSM state code.
- `fault_code` out 2: cause of the latched fault.
- `pulse_cnt` out 32: total accepted pulses.
- `drop_cnt` out 16: total rejected requests.

## Operation
- States and codes: WAIT_RDY=0, ARMED=1, PULSE=2, GAP=3, FAULT=4.
- Reset values: state WAIT_RDY; all outputs 0; window timer 0; window pulse count 0.
- All outputs are registered.
- `laser_en` is 1 exactly when the state is ARMED, PULSE or GAP.
- `trig_out` is 1 exactly when the state is PULSE.
- Transitions are evaluated per edge in this priority order:
  1. `fault_in`=1 in any state other than FAULT → FAULT, `fault_code`=1.
  2. `laser_ready`=0 in ARMED, PULSE or GAP → FAULT, `fault_code`=2.
  3. WAIT_RDY: `laser_ready`=1 → ARMED.
  4. ARMED: `trig_req`=1 and window count < `MAX_PULSES` → PULSE. The request is accepted: `pulse_cnt`+1, window count +1. Phase timer loads 0.
  5. ARMED: `trig_req`=1 and window count = `MAX_PULSES` → stay in ARMED, `drop_cnt`+1.
  6. PULSE: phase timer counts to `PULSE_W`-1, then → GAP with timer reset.
  7. GAP: timer counts to `MIN_GAP`-1, then → ARMED.
  8. FAULT: `fault_clr`=1 and `fault_in`=0 → WAIT_RDY, `fault_code`←0. Otherwise stay in FAULT, including when `fault_clr` is asserted while `fault_in` is still 1.
- Requests arriving in WAIT_RDY, PULSE, GAP or FAULT are dropped and increment `drop_cnt`. Requests are never queued.
- A request accepted in the same cycle that a fault fires does not count: the fault wins, and neither `pulse_cnt` nor the window count changes.
- Window timer:
  - Free-running from 0 to `WINDOW`-1, then wraps. It runs in every state.
  - On the wrap edge, the window count loads 1 if a pulse is accepted on that edge, otherwise 0.
  - The acceptance check on the wrap edge uses the pre-wrap count.
- Counter widths and overflow:
  - `pulse_cnt` wraps modulo 2^32.
  - `drop_cnt` saturates at 0xFFFF.
  - Neither counter is cleared by FAULT; only `rstn` clears them.
- Reset mid-pulse forces `trig_out` and `laser_en` to 0 immediately (asynchronously) and returns the block to WAIT_RDY.

## Timing
- `laser_ready` rising, sampled at edge N → `laser_en`=1 after edge N+1... no: state becomes ARMED at edge N, so `laser_en`=1 from edge N onward (1-cycle latency from input to output).
- `trig_req` sampled high in ARMED at edge M → `trig_out` high after edges M through M+`PULSE_W`-1, i.e. exactly `PULSE_W` cycles. `trig_out` falls at edge M+`PULSE_W`.
- GAP lasts exactly `MIN_GAP` cycles, followed by at least one cycle of ARMED.
- Minimum spacing between consecutive `trig_out` rising edges is `PULSE_W`+`MIN_GAP`+1 cycles.
- Fault sampled at edge F → `trig_out`=0, `laser_en`=0 and `state`=4 after edge F (1-cycle latency).
- Leaving FAULT → WAIT_RDY takes 1 cycle; re-arming takes 1 more cycle if `laser_ready` is 1.

## Test plan
Bench parameters for all scenarios: `PULSE_W`=4, `MIN_GAP`=6, `WINDOW`=100, `MAX_PULSES`=3.

- **Power-up.** Release `rstn`, hold `laser_ready`=0 for 20 cycles, then raise it. Required: `laser_en`=0 and `state`=0 throughout the 20 cycles; `laser_en`=1 and `state`=1 one cycle after `laser_ready` is sampled high.
- **Single pulse and gap.** Pulse `trig_req` for 1 cycle in ARMED. Required: `trig_out` high for 4 cycles, then 6 cycles of GAP, then ARMED; `pulse_cnt`=1. A request issued during GAP gives `drop_cnt`=1 and no pulse.
- **Budget and wrap.** Hold `trig_req`=1 continuously. Required: 3 pulses with rising edges spaced 11 cycles apart, then drops until the window wraps, then pulses resume. `pulse_cnt` increments by exactly 3 per 100-cycle window.
- **External fault mid-pulse.** Assert `fault_in` on the 2nd cycle of PULSE. Required: `trig_out`=0, `laser_en`=0, `state`=4 and `fault_code`=1 one cycle later. Asserting `fault_clr` while `fault_in`=1 has no effect. After `fault_in`=0 and `fault_clr`=1: WAIT_RDY, then ARMED, with `fault_code`=0.
- **Ready loss.** Drop `laser_ready` in GAP. Required: FAULT with `fault_code`=2 and no further pulses until cleared.
- **Async reset mid-pulse, plus saturation.** Assert `rstn` low in PULSE: `trig_out` falls immediately and all outputs are 0. Separately, force `drop_cnt` to 0xFFFE and issue 3 rejected requests: `drop_cnt` reads 0xFFFF.

Source files
------------

// File: rtl/laser_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// laser_pulse_ctrl
//
// Sequences laser trigger pulses once the laser reports ready, and enforces
// the safety limits on them: a fixed pulse width, a forced low gap after
// every pulse, and a cap on the number of pulses accepted per rolling
// window. An external fault or loss of laser_ready latches a shutdown
// (FAULT) that is only left through an explicit fault_clr.
//
// Parameters
//   PULSE_W     trigger high time in clk cycles (>= 1)
//   MIN_GAP     forced low time after each pulse in clk cycles (>= 1)
//   WINDOW      length of the pulse-budget window in clk cycles (>= 2)
//   MAX_PULSES  accepted pulses allowed per window (>= 1)
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   laser_ready  laser power-up complete (synchronous to clk)
//   trig_req     pulse request, one request per high cycle
//   fault_in     external safety fault, active high (synchronous)
//   fault_clr    request to leave FAULT
//   laser_en     laser enable (ARMED, PULSE or GAP)
//   trig_out     laser trigger (PULSE)
//   state        current FSM state code
//   fault_code   cause of the latched fault (1 = external, 2 = ready lost)
//   pulse_cnt    total accepted pulses, wraps modulo 2^32
//   drop_cnt     total rejected requests, saturates at 0xFFFF
// ---------------------------------------------------------------------------
module laser_pulse_ctrl #(
  parameter int unsigned PULSE_W    = 100,
  parameter int unsigned MIN_GAP    = 1000,
  parameter int unsigned WINDOW     = 1000000,
  parameter int unsigned MAX_PULSES = 50
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        laser_ready,
  input  logic        trig_req,
  input  logic        fault_in,
  input  logic        fault_clr,
  output logic        laser_en,
  output logic        trig_out,
  output logic [2:0]  state,
  output logic [1:0]  fault_code,
  output logic [31:0] pulse_cnt,
  output logic [15:0] drop_cnt
);

  // One phase timer is shared by PULSE and GAP, so it is sized for the
  // longer of the two phases.
  localparam int unsigned PHASE_MAX  = (PULSE_W > MIN_GAP) ? PULSE_W : MIN_GAP;
  localparam int unsigned PHASE_BITS = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned WIN_BITS   = $clog2(WINDOW);
  localparam int unsigned WCNT_BITS  = $clog2(MAX_PULSES + 1);

  localparam logic [PHASE_BITS-1:0] PULSE_LAST = PHASE_BITS'(PULSE_W - 1);
  localparam logic [PHASE_BITS-1:0] GAP_LAST   = PHASE_BITS'(MIN_GAP - 1);
  localparam logic [WIN_BITS-1:0]   WIN_LAST   = WIN_BITS'(WINDOW - 1);
  localparam logic [WCNT_BITS-1:0]  WCNT_MAX   = WCNT_BITS'(MAX_PULSES);

  localparam logic [1:0]  CODE_NONE  = 2'd0;
  localparam logic [1:0]  CODE_EXT   = 2'd1;
  localparam logic [1:0]  CODE_READY = 2'd2;
  localparam logic [15:0] DROP_SAT   = 16'hFFFF;

  typedef enum logic [2:0] {
    WAIT_RDY = 3'd0,
    ARMED    = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [WIN_BITS-1:0]   win_timer_q, win_timer_d;
  logic [WCNT_BITS-1:0]  win_count_q, win_count_d;
  logic [1:0]            fault_code_d;
  logic [31:0]           pulse_cnt_d;
  logic [15:0]           drop_cnt_d;
  logic                  laser_en_d;
  logic                  trig_out_d;
  logic                  accept;
  logic                  win_full;
  logic                  win_wrap;
  logic                  active;

  // State register plus every output. All outputs are registered so the
  // driver pins never see combinational glitches; the async reset clears the
  // trigger and enable straight away, even in the middle of a pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= WAIT_RDY;
      phase_q     <= '0;
      win_timer_q <= '0;
      win_count_q <= '0;
      laser_en    <= 1'b0;
      trig_out    <= 1'b0;
      fault_code  <= CODE_NONE;
      pulse_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      win_timer_q <= win_timer_d;
      win_count_q <= win_count_d;
      laser_en    <= laser_en_d;
      trig_out    <= trig_out_d;
      fault_code  <= fault_code_d;
      pulse_cnt   <= pulse_cnt_d;
      drop_cnt    <= drop_cnt_d;
    end
  end

  assign state = state_q;

  // Next-state logic. Safety checks come first so that a fault always wins
  // over anything the normal sequencing would do on the same edge, including
  // accepting a request.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    fault_code_d = fault_code;
    accept       = 1'b0;
    active       = (state_q == ARMED) || (state_q == PULSE) || (state_q == GAP);
    win_full     = (win_count_q >= WCNT_MAX);

    if ((state_q != FAULT) && fault_in) begin
      state_d      = FAULT;
      fault_code_d = CODE_EXT;
      phase_d      = '0;
    end else if (active && !laser_ready) begin
      state_d      = FAULT;
      fault_code_d = CODE_READY;
      phase_d      = '0;
    end else begin
      case (state_q)
        WAIT_RDY: begin
          if (laser_ready) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (trig_req && !win_full) begin
            accept  = 1'b1;
            state_d = PULSE;
            phase_d = '0;
          end
        end
        PULSE: begin
          if (phase_q == PULSE_LAST) begin
            state_d = GAP;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PHASE_BITS'(1);
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            state_d = ARMED;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PHASE_BITS'(1);
          end
        end
        FAULT: begin
          // A clear is ignored while the fault source is still asserted.
          if (fault_clr && !fault_in) begin
            state_d      = WAIT_RDY;
            fault_code_d = CODE_NONE;
          end
        end
        default: begin
          state_d = WAIT_RDY;
          phase_d = '0;
        end
      endcase
    end
  end

  // Pulse-budget window. The timer runs in every state. On the wrap edge the
  // count restarts, but a pulse accepted on that very edge (judged against
  // the pre-wrap count) becomes the first pulse of the new window.
  always_comb begin
    win_wrap    = (win_timer_q == WIN_LAST);
    win_timer_d = win_wrap ? '0 : (win_timer_q + WIN_BITS'(1));
    if (win_wrap) begin
      win_count_d = accept ? WCNT_BITS'(1) : '0;
    end else begin
      win_count_d = accept ? (win_count_q + WCNT_BITS'(1)) : win_count_q;
    end
  end

  // Statistics and registered outputs. Any request that is not accepted is a
  // drop; drop_cnt sticks at all-ones rather than wrapping to zero.
  always_comb begin
    pulse_cnt_d = accept ? (pulse_cnt + 32'd1) : pulse_cnt;
    drop_cnt_d  = drop_cnt;
    if (trig_req && !accept && (drop_cnt != DROP_SAT)) begin
      drop_cnt_d = drop_cnt + 16'd1;
    end
    laser_en_d = (state_d == ARMED) || (state_d == PULSE) || (state_d == GAP);
    trig_out_d = (state_d == PULSE);
  end

endmodule

// File: tb/tb_laser_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_laser_pulse_ctrl
//
// Self-checking bench for laser_pulse_ctrl with PULSE_W=4, MIN_GAP=6,
// WINDOW=100, MAX_PULSES=3. Expected output values are pushed into a
// scoreboard queue as stimulus is applied and popped and compared once the
// DUT has produced them (one clock edge later, or immediately for reset).
// ---------------------------------------------------------------------------
module tb_laser_pulse_ctrl;

  localparam int PW   = 4;
  localparam int GP   = 6;
  localparam int WIN  = 100;
  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        laser_ready = 1'b0;
  logic        trig_req = 1'b0;
  logic        fault_in = 1'b0;
  logic        fault_clr = 1'b0;
  logic        laser_en;
  logic        trig_out;
  logic [2:0]  state;
  logic [1:0]  fault_code;
  logic [31:0] pulse_cnt;
  logic [15:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef enum int {S_STATE, S_EN, S_TRIG, S_CODE, S_PCNT, S_DCNT} sig_t;

  typedef struct {
    string       tag;
    sig_t        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];

  laser_pulse_ctrl #(
    .PULSE_W   (PW),
    .MIN_GAP   (GP),
    .WINDOW    (WIN),
    .MAX_PULSES(MAXP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .laser_ready(laser_ready),
    .trig_req   (trig_req),
    .fault_in   (fault_in),
    .fault_clr  (fault_clr),
    .laser_en   (laser_en),
    .trig_out   (trig_out),
    .state      (state),
    .fault_code (fault_code),
    .pulse_cnt  (pulse_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic req, input logic fin, input logic fclr);
    laser_ready = ready;
    trig_req    = req;
    fault_in    = fin;
    fault_clr   = fclr;
  endtask

  task automatic push_exp(input string tag, input sig_t sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_t s);
    case (s)
      S_STATE: return {29'd0, state};
      S_EN:    return {31'd0, laser_en};
      S_TRIG:  return {31'd0, trig_out};
      S_CODE:  return {30'd0, fault_code};
      S_PCNT:  return pulse_cnt;
      default: return {16'd0, drop_cnt};
    endcase
  endfunction

  task automatic flush();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sig), e.exp);
    end
  endtask

  // Advance one active edge and compare everything queued for it.
  task automatic step();
    @(posedge clk);
    #1;
    flush();
  endtask

  task automatic push_zero(input string tag);
    push_exp({tag, ".state"}, S_STATE, 32'd0);
    push_exp({tag, ".en"},    S_EN,    32'd0);
    push_exp({tag, ".trig"},  S_TRIG,  32'd0);
    push_exp({tag, ".code"},  S_CODE,  32'd0);
    push_exp({tag, ".pcnt"},  S_PCNT,  32'd0);
    push_exp({tag, ".dcnt"},  S_DCNT,  32'd0);
  endtask

  // Reset is released just after an edge; the following edge is edge 1.
  task automatic do_reset(input logic ready);
    rstn = 1'b0;
    applyStimulus(ready, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push_zero("reset");
    flush();
    rstn = 1'b1;
  endtask

  // Holds laser_ready high and trig_req high from edge first_edge on, and
  // checks every edge against the list of edges at which a pulse must start.
  task automatic run_budget(input string tag, input int first_edge, input int last_edge);
    int n_acc;
    int last_a;
    int drops;
    logic [31:0] st;
    do_reset(1'b1);
    n_acc  = 0;
    last_a = -1000;
    drops  = 0;
    for (int e = 1; e <= last_edge; e++) begin
      applyStimulus(1'b1, (e >= first_edge), 1'b0, 1'b0);
      if ((n_acc < acc_q.size()) && (acc_q[n_acc] == e)) begin
        n_acc++;
        last_a = e;
      end else if (e >= first_edge) begin
        drops++;
      end
      if (e - last_a < PW)            st = 32'd2;
      else if (e - last_a < PW + GP)  st = 32'd3;
      else                            st = 32'd1;
      push_exp({tag, ".state"}, S_STATE, st);
      push_exp({tag, ".trig"},  S_TRIG,  (st == 32'd2) ? 32'd1 : 32'd0);
      push_exp({tag, ".pcnt"},  S_PCNT,  n_acc);
      push_exp({tag, ".dcnt"},  S_DCNT,  drops);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Power-up: ready held low for 20 cycles, then raised.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      push_exp("pwr.state", S_STATE, 32'd0);
      push_exp("pwr.en",    S_EN,    32'd0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("pwr.arm.state", S_STATE, 32'd1);
    push_exp("pwr.arm.en",    S_EN,    32'd1);
    step();

    // Single pulse, gap, and a request dropped during the gap.
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    push_exp("one.state", S_STATE, 32'd2);
    push_exp("one.trig",  S_TRIG,  32'd1);
    push_exp("one.en",    S_EN,    32'd1);
    push_exp("one.pcnt",  S_PCNT,  32'd1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < PW; i++) begin
      push_exp("one.pulse.state", S_STATE, 32'd2);
      push_exp("one.pulse.trig",  S_TRIG,  32'd1);
      step();
    end
    for (int g = 0; g < GP; g++) begin
      applyStimulus(1'b1, (g == 1), 1'b0, 1'b0);
      push_exp("gap.state", S_STATE, 32'd3);
      push_exp("gap.trig",  S_TRIG,  32'd0);
      push_exp("gap.en",    S_EN,    32'd1);
      push_exp("gap.dcnt",  S_DCNT,  (g >= 1) ? 32'd1 : 32'd0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("rearm.state", S_STATE, 32'd1);
    push_exp("rearm.trig",  S_TRIG,  32'd0);
    push_exp("rearm.pcnt",  S_PCNT,  32'd1);
    push_exp("rearm.dcnt",  S_DCNT,  32'd1);
    step();

    // Budget with continuous requests: 3 per window, resuming after wraps.
    acc_q = {2, 13, 24, 101, 112, 123, 201, 212, 223};
    run_budget("budget", 2, 230);

    // A pulse accepted on the wrap edge is the first of the new window.
    acc_q = {100, 111, 122, 201, 212, 223};
    run_budget("wrapacc", 100, 230);

    // External fault on the 2nd cycle of a pulse.
    do_reset(1'b1);
    push_exp("flt.arm", S_STATE, 32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    push_exp("flt.p1.state", S_STATE, 32'd2);
    push_exp("flt.p1.pcnt",  S_PCNT,  32'd1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("flt.p2.trig", S_TRIG, 32'd1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("flt.hit.state", S_STATE, 32'd4);
    push_exp("flt.hit.trig",  S_TRIG,  32'd0);
    push_exp("flt.hit.en",    S_EN,    32'd0);
    push_exp("flt.hit.code",  S_CODE,  32'd1);
    push_exp("flt.hit.pcnt",  S_PCNT,  32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    push_exp("flt.clrhi.state", S_STATE, 32'd4);
    push_exp("flt.clrhi.code",  S_CODE,  32'd1);
    push_exp("flt.clrhi.dcnt",  S_DCNT,  32'd1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    push_exp("flt.clrhi2.state", S_STATE, 32'd4);
    push_exp("flt.clrhi2.en",    S_EN,    32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    push_exp("flt.clr.state", S_STATE, 32'd0);
    push_exp("flt.clr.code",  S_CODE,  32'd0);
    push_exp("flt.clr.en",    S_EN,    32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("flt.rearm.state", S_STATE, 32'd1);
    push_exp("flt.rearm.en",    S_EN,    32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    push_exp("flt.race.state", S_STATE, 32'd4);
    push_exp("flt.race.trig",  S_TRIG,  32'd0);
    push_exp("flt.race.pcnt",  S_PCNT,  32'd1);
    step();

    // Ready lost during GAP.
    do_reset(1'b1);
    push_exp("rdy.arm", S_STATE, 32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    push_exp("rdy.pulse", S_STATE, 32'd2);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (PW - 1) step();
    push_exp("rdy.gap", S_STATE, 32'd3);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("rdy.lost.state", S_STATE, 32'd4);
    push_exp("rdy.lost.code",  S_CODE,  32'd2);
    push_exp("rdy.lost.en",    S_EN,    32'd0);
    step();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      push_exp("rdy.hold.state", S_STATE, 32'd4);
      push_exp("rdy.hold.trig",  S_TRIG,  32'd0);
      push_exp("rdy.hold.pcnt",  S_PCNT,  32'd1);
      push_exp("rdy.hold.dcnt",  S_DCNT,  k);
      step();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    push_exp("rdy.clr.state", S_STATE, 32'd0);
    push_exp("rdy.clr.code",  S_CODE,  32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("rdy.rearm", S_STATE, 32'd1);
    step();

    // Asynchronous reset in the middle of a pulse.
    do_reset(1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("arst.pre.trig", S_TRIG, 32'd1);
    step();
    #3;
    rstn = 1'b0;
    #1;
    push_zero("arst");
    flush();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    // drop_cnt saturation, preloaded to one below the limit.
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      push_exp("sat.dcnt",  S_DCNT,  32'h0000FFFF);
      push_exp("sat.state", S_STATE, 32'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
